// File: rtl/bp_table_clear_arbiter.sv
// bp_table_clear_arbiter: write-port owner for the branch-predictor tag and
// target RAMs. Passes execution-stage updates straight through when idle and
// runs a set-by-set invalidation sweep of every tag bank after reset or on
// clear_req, gating fetch-side prediction use until the sweep completes.
// Optional build macro: BP_CLEAR_STATS_EN adds saturating dropped-update and
// completed-sweep counters.
module bp_table_clear_arbiter #(
  parameter int unsigned ENTRIES   = 512,
  parameter int unsigned WAYS      = 2,
  parameter int unsigned TAG_ENT_W = 24,
  localparam int unsigned ADDR_W   = $clog2(ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_req,
  input  logic [WAYS-1:0]          upd_tag_we,
  input  logic [WAYS-1:0]          upd_target_we,
  input  logic [WAYS*ADDR_W-1:0]   upd_addr,
  input  logic [TAG_ENT_W-1:0]     upd_tag_data,
  input  logic [31:0]              upd_target_pc,
  output logic [WAYS-1:0]          tag_we,
  output logic [WAYS-1:0]          target_we,
  output logic [WAYS*ADDR_W-1:0]   wr_addr,
  output logic [TAG_ENT_W-1:0]     tag_wdata,
  output logic [31:0]              target_wdata,
`ifdef BP_CLEAR_STATS_EN
  output logic [15:0]              dropped_upd_cnt,
  output logic [15:0]              sweep_cnt,
`endif
  output logic                     pred_enable,
  output logic                     clear_busy,
  output logic                     clear_done
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                pred_q;
  logic                busy_q;

  // Final sweep write; a coincident clear_req restarts the sweep instead.
  assign clear_done  = (state_q == CLEAR) && (idx_q == LAST_IDX) && !clear_req;
  assign pred_enable = pred_q;
  assign clear_busy  = busy_q;

  // Sweep sequencer: state, set index and the registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      pred_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            pred_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (clear_req) begin
            idx_q <= '0;
          end else if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pred_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= CLEAR;
          idx_q   <= '0;
          pred_q  <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Write-port mux: sweep owns the tag banks in CLEAR, updates pass through in IDLE.
  always_comb begin
    tag_we       = upd_tag_we;
    target_we    = upd_target_we;
    wr_addr      = upd_addr;
    tag_wdata    = upd_tag_data;
    target_wdata = upd_target_pc;
    if (state_q == CLEAR) begin
      tag_we    = '1;
      target_we = '0;
      wr_addr   = {WAYS{idx_q}};
      tag_wdata = '0;
    end
  end

`ifdef BP_CLEAR_STATS_EN
  logic [15:0] drop_cnt_q;
  logic [15:0] sweep_cnt_q;

  assign dropped_upd_cnt = drop_cnt_q;
  assign sweep_cnt       = sweep_cnt_q;

  // Saturating counters of updates lost to a sweep and of completed sweeps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q  <= '0;
      sweep_cnt_q <= '0;
    end else begin
      if ((state_q == CLEAR) && (|upd_tag_we) && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      if (clear_done && (sweep_cnt_q != '1)) begin
        sweep_cnt_q <= sweep_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bp_table_clear_arbiter.sv
// Directed bench for bp_table_clear_arbiter at ENTRIES=8, WAYS=2.
module tb_bp_table_clear_arbiter;

  localparam int unsigned ENTRIES   = 8;
  localparam int unsigned WAYS      = 2;
  localparam int unsigned TAG_ENT_W = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_req;
  logic [1:0]  upd_tag_we;
  logic [1:0]  upd_target_we;
  logic [5:0]  upd_addr;
  logic [23:0] upd_tag_data;
  logic [31:0] upd_target_pc;
  logic [1:0]  tag_we;
  logic [1:0]  target_we;
  logic [5:0]  wr_addr;
  logic [23:0] tag_wdata;
  logic [31:0] target_wdata;
  logic        pred_enable;
  logic        clear_busy;
  logic        clear_done;
`ifdef BP_CLEAR_STATS_EN
  logic [15:0] dropped_upd_cnt;
  logic [15:0] sweep_cnt;
`endif

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  bp_table_clear_arbiter #(
    .ENTRIES  (ENTRIES),
    .WAYS     (WAYS),
    .TAG_ENT_W(TAG_ENT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_req    (clear_req),
    .upd_tag_we   (upd_tag_we),
    .upd_target_we(upd_target_we),
    .upd_addr     (upd_addr),
    .upd_tag_data (upd_tag_data),
    .upd_target_pc(upd_target_pc),
    .tag_we       (tag_we),
    .target_we    (target_we),
    .wr_addr      (wr_addr),
    .tag_wdata    (tag_wdata),
    .target_wdata (target_wdata),
`ifdef BP_CLEAR_STATS_EN
    .dropped_upd_cnt(dropped_upd_cnt),
    .sweep_cnt    (sweep_cnt),
`endif
    .pred_enable  (pred_enable),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done)
  );

  typedef struct {
    logic [1:0]  we;
    logic [1:0]  twe;
    logic [5:0]  addr;
    logic [23:0] tdata;
    logic [31:0] pc;
    logic [1:0]  exp_tag_we;
    logic [1:0]  exp_target_we;
    logic [5:0]  exp_wr_addr;
    logic [23:0] exp_tag_wdata;
    logic [31:0] exp_target_wdata;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_req     = 1'b0;
    upd_tag_we    = 2'b00;
    upd_target_we = 2'b00;
    upd_addr      = 6'o00;
    upd_tag_data  = 24'h0;
    upd_target_pc = 32'h0;
  endtask

  // Called at posedge+1; checks one sweep cycle at the falling edge, returns at next posedge+1.
  task automatic sweep_step(input int unsigned i, input logic exp_done);
    logic [2:0] ix;
    ix = i[2:0];
    @(negedge clk);
    chk("sweep_tag_we", 64'(tag_we), 64'(2'b11));
    chk("sweep_target_we", 64'(target_we), 64'(2'b00));
    chk("sweep_wr_addr", 64'(wr_addr), 64'({ix, ix}));
    chk("sweep_tag_wdata", 64'(tag_wdata), 64'(24'h0));
    chk("sweep_pred_enable", 64'(pred_enable), 64'(1'b0));
    chk("sweep_clear_busy", 64'(clear_busy), 64'(1'b1));
    chk("sweep_clear_done", 64'(clear_done), 64'(exp_done));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cycles;
    int unsigned dones;
    logic        timeout;

    vecs[0] = '{2'b01, 2'b01, 6'o05, 24'h801234, 32'h8000_0040,
                2'b01, 2'b01, 6'o05, 24'h801234, 32'h8000_0040};
    vecs[1] = '{2'b10, 2'b00, 6'o36, 24'hABCDEF, 32'h0000_1000,
                2'b10, 2'b00, 6'o36, 24'hABCDEF, 32'h0000_1000};
    vecs[2] = '{2'b10, 2'b10, 6'o70, 24'hFFFFFF, 32'hFFFF_FFFC,
                2'b10, 2'b10, 6'o70, 24'hFFFFFF, 32'hFFFF_FFFC};
    vecs[3] = '{2'b00, 2'b00, 6'o12, 24'h000000, 32'h0000_0000,
                2'b00, 2'b00, 6'o12, 24'h000000, 32'h0000_0000};

    // Reset state, then the power-on sweep.
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_tag_we", 64'(tag_we), 64'(2'b11));
    chk("rst_wr_addr", 64'(wr_addr), 64'(6'o00));
    chk("rst_pred_enable", 64'(pred_enable), 64'(1'b0));
    chk("rst_clear_busy", 64'(clear_busy), 64'(1'b1));
    chk("rst_clear_done", 64'(clear_done), 64'(1'b0));
`ifdef BP_CLEAR_STATS_EN
    chk("rst_dropped_cnt", 64'(dropped_upd_cnt), 64'(16'd0));
    chk("rst_sweep_cnt", 64'(sweep_cnt), 64'(16'd0));
`endif
    tick();
    rst = 1'b1;
    for (int unsigned i = 0; i < ENTRIES; i++) sweep_step(i, i == ENTRIES - 1);
    @(negedge clk);
    chk("post_sweep_pred_enable", 64'(pred_enable), 64'(1'b1));
    chk("post_sweep_clear_busy", 64'(clear_busy), 64'(1'b0));
    chk("post_sweep_tag_we", 64'(tag_we), 64'(2'b00));
    tick();

    // IDLE pass-through vectors.
    for (int unsigned v = 0; v < 4; v++) begin
      upd_tag_we    = vecs[v].we;
      upd_target_we = vecs[v].twe;
      upd_addr      = vecs[v].addr;
      upd_tag_data  = vecs[v].tdata;
      upd_target_pc = vecs[v].pc;
      @(negedge clk);
      chk("idle_tag_we", 64'(tag_we), 64'(vecs[v].exp_tag_we));
      chk("idle_target_we", 64'(target_we), 64'(vecs[v].exp_target_we));
      chk("idle_wr_addr", 64'(wr_addr), 64'(vecs[v].exp_wr_addr));
      chk("idle_tag_wdata", 64'(tag_wdata), 64'(vecs[v].exp_tag_wdata));
      chk("idle_target_wdata", 64'(target_wdata), 64'(vecs[v].exp_target_wdata));
      chk("idle_pred_enable", 64'(pred_enable), 64'(1'b1));
      tick();
    end

    // clear_req in IDLE with a same-cycle update; drop an update at idx 4.
    clear_req     = 1'b1;
    upd_tag_we    = 2'b10;
    upd_target_we = 2'b00;
    upd_addr      = 6'o20;
    upd_tag_data  = 24'h8000AA;
    @(negedge clk);
    chk("req_idle_tag_we", 64'(tag_we), 64'(2'b10));
    chk("req_idle_wr_addr", 64'(wr_addr), 64'(6'o20));
    chk("req_idle_tag_wdata", 64'(tag_wdata), 64'(24'h8000AA));
    chk("req_idle_pred_enable", 64'(pred_enable), 64'(1'b1));
    tick();
    idle_inputs();
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (i == 4) begin
        upd_tag_we    = 2'b01;
        upd_target_we = 2'b01;
        upd_addr      = 6'o01;
        upd_tag_data  = 24'h812345;
        upd_target_pc = 32'h8000_0100;
      end else begin
        idle_inputs();
      end
      sweep_step(i, i == ENTRIES - 1);
    end
    idle_inputs();
    @(negedge clk);
    chk("req_sweep_end_pred", 64'(pred_enable), 64'(1'b1));
`ifdef BP_CLEAR_STATS_EN
    chk("stats_dropped_cnt", 64'(dropped_upd_cnt), 64'(16'd1));
    chk("stats_sweep_cnt", 64'(sweep_cnt), 64'(16'd2));
`endif
    tick();

    // clear_req at idx 3 restarts the sweep: 12 sweep cycles, one clear_done.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cycles  = 0;
    dones   = 0;
    timeout = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i == 3) clear_req = 1'b1;
      @(negedge clk);
      chk("restart_pre_wr_addr", 64'(wr_addr), 64'({i[2:0], i[2:0]}));
      if (clear_done) dones++;
      cycles++;
      tick();
      clear_req = 1'b0;
    end
    @(negedge clk);
    chk("restart_idx0", 64'(wr_addr), 64'(6'o00));
    chk("restart_busy", 64'(clear_busy), 64'(1'b1));
    for (int unsigned k = 0; k < 40; k++) begin
      if (pred_enable) begin
        timeout = 1'b0;
        break;
      end
      cycles++;
      if (clear_done) dones++;
      @(negedge clk);
    end
    chk("restart_timeout", 64'(timeout), 64'(1'b0));
    chk("restart_cycles", 64'(cycles), 64'(12));
    chk("restart_dones", 64'(dones), 64'(1));
    tick();

    // clear_req coinciding with the final index: no clear_done, sweep restarts.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (ENTRIES - 1) tick();
    clear_req = 1'b1;
    @(negedge clk);
    chk("coinc_wr_addr", 64'(wr_addr), 64'(6'o77));
    chk("coinc_clear_done", 64'(clear_done), 64'(1'b0));
    tick();
    clear_req = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) sweep_step(i, i == ENTRIES - 1);
    @(negedge clk);
    chk("coinc_end_pred", 64'(pred_enable), 64'(1'b1));
    tick();

    // Reset asserted mid-sweep at idx 5.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("midrst_pre_wr_addr", 64'(wr_addr), 64'(6'o55));
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_wr_addr", 64'(wr_addr), 64'(6'o00));
    chk("midrst_tag_we", 64'(tag_we), 64'(2'b11));
    chk("midrst_pred_enable", 64'(pred_enable), 64'(1'b0));
    chk("midrst_clear_busy", 64'(clear_busy), 64'(1'b1));
    chk("midrst_clear_done", 64'(clear_done), 64'(1'b0));
    tick();
    rst = 1'b1;
    for (int unsigned i = 0; i < ENTRIES; i++) sweep_step(i, i == ENTRIES - 1);
    @(negedge clk);
    chk("midrst_end_pred", 64'(pred_enable), 64'(1'b1));
`ifdef BP_CLEAR_STATS_EN
    chk("midrst_dropped_cnt", 64'(dropped_upd_cnt), 64'(16'd0));
    chk("midrst_sweep_cnt", 64'(sweep_cnt), 64'(16'd1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
